// File: rtl/jk_excitation_driver.sv
// JK excitation driver.
// Takes a target word for an external bank of JK flip-flops, drives the J/K
// excitation that moves the bank from its current state to the target for a
// single clock, waits a programmable settle time, then checks the fed-back Q
// outputs against the target and reports the result with a one-cycle done
// pulse and a saturating mismatch counter.
//
// state         | meaning
// --------------+---------------------------------------------------------
// S_IDLE        | ready for a target; j/k held at zero
// S_DRIVE       | j/k carry the excitation for exactly one cycle
// S_SETTLE_WAIT | j/k back at zero, counting down SETTLE cycles
// S_CHECK       | first cycle samples q_fb; second cycle reports done/err
module jk_excitation_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE_WAIT,
        S_CHECK
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t           state_q;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic [3:0]       wait_q;
    logic             sampled_q;
    logic             mismatch_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;

    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             mismatch_d;
    logic [7:0]       err_cnt_d;

    // Excitation is formed from the live q_fb/tgt_data at the accept edge, so
    // j_q/k_q themselves act as the snapshot of (q_snap, tgt_reg); the J=K=1
    // toggle code cannot occur because a bit is never both 0->1 and 1->0.
    always_comb begin
        j_d        = ~q_fb & tgt_data;
        k_d        = q_fb & ~tgt_data;
        mismatch_d = (q_fb != tgt_q);
        err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    // Sequencer with all outputs registered; clr aborts any transfer in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            wait_q     <= '0;
            sampled_q  <= 1'b0;
            mismatch_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            j_q    <= '0;
            k_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (tgt_valid) begin
                        tgt_q   <= tgt_data;
                        j_q     <= j_d;
                        k_q     <= k_d;
                        ready_q <= 1'b0;
                        state_q <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_q  <= SETTLE_LD;
                    state_q <= S_SETTLE_WAIT;
                end
                S_SETTLE_WAIT: begin
                    if (wait_q == 4'd0) begin
                        sampled_q <= 1'b0;
                        state_q   <= S_CHECK;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_CHECK: begin
                    // Only the first CHECK cycle looks at q_fb; the second
                    // publishes the registered verdict alongside tgt_ready.
                    if (!sampled_q) begin
                        mismatch_q <= mismatch_d;
                        sampled_q  <= 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= mismatch_q;
                        if (mismatch_q) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tgt_ready = ready_q;
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: doc/jk_excitation_driver.md
JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 Parameter WIDTH, default 4: number of JK flip-flop bits driven.
REQ-002 Parameter SETTLE, default 1: number of clocks waited after drive before sampling feedback; legal range 1-15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 tgt_valid  input  1  target word offered.
REQ-006 tgt_data  input  WIDTH  desired next state of the external JK bank.
REQ-007 tgt_ready  output  1  block can accept a target.
REQ-008 q_fb  input  WIDTH  Q outputs fed back from the external JK bank.
REQ-009 j  output  WIDTH  J drive to the external JK bank.
REQ-010 k  output  WIDTH  K drive to the external JK bank.
REQ-011 done  output  1  one-cycle pulse when a transfer completes.
REQ-012 err  output  1  valid with done; 1 = feedback mismatched target.
REQ-013 err_count  output  8  running count of mismatches.

Function
REQ-014 FSM states: IDLE, DRIVE, SETTLE_WAIT, CHECK; all registered.
REQ-015 IDLE: tgt_ready=1, j=0, k=0; all other states: tgt_ready=0.
REQ-016 IDLE: tgt_valid=1 on an edge -> capture tgt_data into tgt_reg, capture q_fb into q_snap, go to DRIVE.
REQ-017 IDLE: tgt_valid=1 while not in IDLE -> ignored; no capture, no queuing.
REQ-018 DRIVE lasts exactly one cycle: j = ~q_snap & tgt_reg, k = q_snap & ~tgt_reg, per bit (don't-cares resolved to 0).
REQ-019 Result: unchanged bits get J=K=0 (hold); 0->1 bits get J=1,K=0; 1->0 bits get J=0,K=1; J=K=1 (toggle) never driven.
REQ-020 j and k registered; zero in every state except DRIVE.
REQ-021 DRIVE -> SETTLE_WAIT; wait counter loaded with SETTLE-1; SETTLE_WAIT decrements, exits to CHECK when counter = 0 (SETTLE=1 -> one cycle in SETTLE_WAIT).
REQ-022 CHECK lasts one cycle: compare q_fb to tgt_reg; next edge asserts done=1 for one cycle, err=1 if unequal else 0, returns to IDLE.
REQ-023 Mismatch increments err_count by 1; saturates at 255, no wrap.
REQ-024 err holds its last value until the next done; done never high two consecutive cycles.
REQ-025 Latency: accept edge to done high = 3 + SETTLE cycles; tgt_ready reasserts same cycle as done.
REQ-026 Target equal to q_snap is legal: DRIVE produces j=k=0 and flow completes normally.
REQ-027 q_fb changing during DRIVE/SETTLE_WAIT has no effect; only the CHECK-cycle value is compared.

Reset
REQ-028 clr=0 immediately forces state IDLE, j=0, k=0, done=0, err=0, err_count=0, tgt_ready=1 (no clock required).
REQ-029 clr asserted mid-transfer aborts it; no done pulse is produced for the aborted target.
REQ-030 After clr rises, first target is accepted on the first rising edge with tgt_valid=1.

Verification
REQ-031 WIDTH=4, q_fb=0000, target 1010 -> DRIVE cycle j=1010 k=0000; bank reaches 1010; done=1, err=0, err_count=0.
REQ-032 q_fb=1010, target 0110 -> j=0100 k=1000; correct bank -> err=0; done 4 cycles after accept (SETTLE=1).
REQ-033 Bank stuck at 0000, target 1111 -> done=1, err=1, err_count=1; repeat 300 times -> err_count=255.
REQ-034 tgt_valid held high continuously with alternating targets 0011/1100 -> one accept per 4+SETTLE cycles, tgt_ready low between, no dropped or duplicated done.
REQ-035 clr pulsed low during SETTLE_WAIT -> outputs zero asynchronously, no done, err_count=0, next target completes normally.
REQ-036 Target equal to current q_fb (0101 -> 0101) -> j=k=0000 throughout, done=1, err=0.
